// File: rtl/vector_add_seq.sv
// Streaming sequencer for an N-lane vector_add: loads operand vectors element-wise,
// holds them on the adder while its latency elapses, then drains the sum element-wise.
module vector_add_seq #(
  parameter int N       = 16,
  parameter int W       = 32,
  parameter int ADD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] vadd_a [N],
  output logic [W-1:0] vadd_b [N],
  input  logic [W-1:0] vadd_c [N],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [31:0]  vec_count,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);
  localparam int WW = $clog2(ADD_LAT + 1) + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  elem_cnt, elem_cnt_nxt;
  logic [WW-1:0]  wait_cnt, wait_cnt_nxt;
  logic [W-1:0]   a_buf   [N];
  logic [W-1:0]   b_buf   [N];
  logic [W-1:0]   res_buf [N];
  logic           in_fire, cap_res, done_nxt, last_elem;

  assign last_elem = (elem_cnt == CW'(N - 1));

  // Handshakes: a beat moves on a rising edge where valid && ready are both high.
  // flush withdraws in_ready/out_valid for its cycle so no beat can move while aborting.
  always_comb begin
    state_nxt    = state;
    elem_cnt_nxt = elem_cnt;
    wait_cnt_nxt = wait_cnt;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    in_fire      = 1'b0;
    cap_res      = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = !flush;
        if (in_valid && !flush) begin
          in_fire = 1'b1;
          if (last_elem) begin
            elem_cnt_nxt = '0;
            wait_cnt_nxt = '0;
            state_nxt    = WAIT;
          end else begin
            elem_cnt_nxt = elem_cnt + CW'(1);
          end
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + WW'(1);
        if (wait_cnt == WW'(ADD_LAT)) begin
          cap_res   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = !flush;
        out_data  = res_buf[elem_cnt];
        out_last  = last_elem;
        if (out_ready && !flush) begin
          if (last_elem) begin
            elem_cnt_nxt = '0;
            done_nxt     = 1'b1;
            state_nxt    = LOAD;
          end else begin
            elem_cnt_nxt = elem_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
    if (flush) begin
      state_nxt    = LOAD;
      elem_cnt_nxt = '0;
      wait_cnt_nxt = '0;
      cap_res      = 1'b0;
      done_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      elem_cnt  <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      vec_count <= '0;
    end else begin
      state     <= state_nxt;
      elem_cnt  <= elem_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      done      <= done_nxt;
      if (done_nxt) vec_count <= vec_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i]   <= '0;
        b_buf[i]   <= '0;
        res_buf[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        a_buf[elem_cnt] <= in_a;
        b_buf[elem_cnt] <= in_b;
      end
      if (cap_res) begin
        for (int i = 0; i < N; i++) res_buf[i] <= vadd_c[i];
      end
    end
  end

  // Operands stay on the adder in every state, so they are stable for the whole WAIT.
  assign vadd_a    = a_buf;
  assign vadd_b    = b_buf;
  assign busy      = (state != LOAD) || (elem_cnt != '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_vector_add_seq.sv
// Self-checking bench for vector_add_seq with a registered vector_add model attached.
module tb_vector_add_seq;
  localparam int N       = 16;
  localparam int W       = 32;
  localparam int ADD_LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_data;
  logic         out_last, busy, done;
  logic [31:0]  vec_count;
  logic [1:0]   dbg_state;
  logic [W-1:0] vadd_a [N];
  logic [W-1:0] vadd_b [N];
  logic [W-1:0] vadd_c [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_edge  = 0;
  int exp_vec  = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];

  vector_add_seq #(.N(N), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .vadd_a(vadd_a), .vadd_b(vadd_b), .vadd_c(vadd_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .vec_count(vec_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered one-cycle adder standing in for vector_add.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) vadd_c[i] <= vadd_a[i] + vadd_b[i];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive nb operand beats from va/vb; a complete vector enqueues its element-wise sums.
  task automatic send_vec(input int nb, input int gap_pct);
    int i = 0;
    int budget = 0;
    logic [W-1:0] s;
    while (i < nb && budget < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_a = va[i];
      in_b = vb[i];
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
        hs_edge = cyc + 1;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (i != nb) begin
      n_fail++;
      $display("FAIL send_timeout: got %0d beats expected %0d", i, nb);
    end
    if (nb == N) begin
      for (int k = 0; k < N; k++) begin
        s = va[k] + vb[k];
        exp_q.push_back(s);
      end
    end
  endtask

  // mode 0: out_ready held high; 1: pattern 1,0,0,1; 2: random. Stops after nb accepted beats.
  task automatic recv_vec(input int mode, input int nb);
    int idx = 0;
    int budget = 0;
    int k = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] exp;
    while (idx < nb && budget < 2000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: out_ready = $urandom_range(1);
      endcase
      k++;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL in_ready_busy: got %b expected 0 (idx %0d)", in_ready, idx);
      end
      if (out_valid) begin
        if (first) begin
          first = 1'b0;
          n_checks++;
          if (cyc - hs_edge != ADD_LAT + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc - hs_edge, ADD_LAT + 1);
          end
        end
        if (stalled) begin
          n_checks++;
          if (out_data !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got %0h expected %0h", out_data, held);
          end
        end
        exp = (exp_q.size() > 0) ? exp_q[0] : '0;
        n_checks++;
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL out_data[%0d]: got %0h expected %0h", idx, out_data, exp);
        end
        n_checks++;
        if (out_last !== (idx == N - 1)) begin
          n_fail++;
          $display("FAIL out_last[%0d]: got %b expected %b", idx, out_last, idx == N - 1);
        end
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (idx != nb) begin
      n_fail++;
      $display("FAIL recv_timeout: got %0d beats expected %0d", idx, nb);
    end
    if (nb == N) begin
      exp_vec++;
      n_checks++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_pulse: got %b expected 1", done);
      end
      n_checks++;
      if (vec_count !== 32'(exp_vec)) begin
        n_fail++;
        $display("FAIL vec_count: got %0d expected %0d", vec_count, exp_vec);
      end
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_load: got in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                 in_ready, busy, out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_width: got %b expected 0", done);
      end
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      va[i] = W'(i);
      vb[i] = W'(N - i);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
        done !== 1'b0 || vec_count !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got in_ready=%b out_valid=%b out_last=%b data=%0h done=%b cnt=%0d busy=%b",
               in_ready, out_valid, out_last, out_data, done, vec_count, busy);
    end
    n_checks++;
    if (vadd_a[0] !== '0 || vadd_b[N-1] !== '0) begin
      n_fail++;
      $display("FAIL reset_vadd: got a0=%0h bN=%0h expected 0", vadd_a[0], vadd_b[N-1]);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_ramp();
    send_vec(N, 0);
    recv_vec(0, N);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++) begin
      va[i] = '1;
      vb[i] = W'(i + 1);
    end
    send_vec(N, 0);
    recv_vec(0, N);
  endtask

  task automatic test_backpressure();
    load_random();
    send_vec(N, 0);
    recv_vec(1, N);
  endtask

  task automatic test_gapped();
    load_ramp();
    send_vec(N, 50);
    recv_vec(0, N);
  endtask

  task automatic test_flush();
    load_random();
    send_vec(7, 0);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec_count !== 32'(exp_vec) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: got busy=%b cnt=%0d done=%b expected 0 %0d 0", busy, vec_count, done, exp_vec);
    end
    for (int i = 0; i < N; i++) begin
      va[i] = W'(2 * i);
      vb[i] = W'(1);
    end
    send_vec(N, 0);
    recv_vec(0, N);
  endtask

  task automatic test_reset_mid_drain();
    load_random();
    send_vec(N, 0);
    recv_vec(0, 5);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || vec_count !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got out_valid=%b cnt=%0d in_ready=%b busy=%b expected 0 0 1 0",
               out_valid, vec_count, in_ready, busy);
    end
    exp_q.delete();
    exp_vec = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_random();
    send_vec(N, 0);
    recv_vec(0, N);
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 4; v++) begin
      load_random();
      send_vec(N, $urandom_range(40));
      recv_vec(2, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_gapped();
    test_flush();
    test_reset_mid_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
